// File: rtl/eth_parser_pkg.sv
// eth_parser_pkg: shared Ethernet types for the RX parser and the TX frame builder.
// Build macro ETH_TX_PAD_EN adds the PAD state to the TX state encoding.
package eth_parser_pkg;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
   localparam logic [15:0] ETHERTYPE_IPV6 = 16'h86DD;
   localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;

   localparam int ETH_HDR_BYTES       = 14;
   localparam int ETH_MIN_FRAME_BYTES = 60;

   typedef struct packed {
      logic [47:0] dest_mac;
      logic [47:0] src_mac;
      logic [15:0] ethertype;
      logic        is_ipv4;
      logic        is_arp;
      logic        is_ipv6;
      logic        is_vlan;
   } eth_metadata_t;

`ifdef ETH_TX_PAD_EN
   typedef enum logic [1:0] {
      TX_IDLE,
      TX_HDR,
      TX_PAYLOAD,
      TX_PAD
   } tx_state_t;
`else
   typedef enum logic [1:0] {
      TX_IDLE,
      TX_HDR,
      TX_PAYLOAD
   } tx_state_t;
`endif

   // Header bytes in wire order: dest MAC, src MAC, ethertype, MSB first.
   function automatic logic [ETH_HDR_BYTES*8-1:0] eth_hdr_pack(input eth_metadata_t m);
      return {m.dest_mac, m.src_mac, m.ethertype};
   endfunction

endpackage

// File: rtl/eth_tx_out_reg.sv
// eth_tx_out_reg: single-stage AXI-Stream output register with the advance
// (load-enable) signal and the registered end-of-frame pulse.
module eth_tx_out_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   input  logic                  m_axis_tready,
   output logic                  adv,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  frame_done
);

   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  done_q, done_d;

   assign adv = !valid_q || m_axis_tready;

   // Next register contents: data/last only change when the slot is free or draining.
   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      if (adv) begin
         valid_d = load;
         last_d  = load && load_last;
         if (load) begin
            data_d = load_data;
         end
      end
      done_d = valid_q && m_axis_tready && last_q;
   end

   // Output register state with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q;
   assign frame_done    = done_q;

endmodule

// File: rtl/eth_frame_builder.sv
// eth_frame_builder: prepends the 14-byte Ethernet header from a descriptor to a
// byte-wide payload stream. Build macro ETH_TX_PAD_EN zero-pads short frames up
// to MIN_FRAME_BYTES (header included, FCS excluded).
module eth_frame_builder
   import eth_parser_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  eth_metadata_t         s_hdr,
   input  logic                  s_hdr_valid,
   output logic                  s_hdr_ready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  frame_done
);

   localparam int HDR_BITS = ETH_HDR_BYTES * 8;

   if (DATA_WIDTH != 8 || MIN_FRAME_BYTES < 1) begin : g_param_check
      $error("eth_frame_builder: only DATA_WIDTH == 8 and MIN_FRAME_BYTES >= 1 are supported");
   end

   tx_state_t             state_q, state_d;
   logic [HDR_BITS-1:0]   hdr_sr_q, hdr_sr_d, hdr_bytes;
   logic [3:0]            hdr_idx_q, hdr_idx_d;
   logic [15:0]           byte_cnt_q, byte_cnt_d, cnt_inc;
   logic                  hdr_ready_q, hdr_ready_d;
   logic                  adv, load, load_last, payload_ready;
   logic [DATA_WIDTH-1:0] load_data;
`ifdef ETH_TX_PAD_EN
   logic [16:0]           cnt_plus1;
`endif

   logic unused_hdr_flags;
   assign unused_hdr_flags = ^{s_hdr.is_ipv4, s_hdr.is_arp, s_hdr.is_ipv6, s_hdr.is_vlan};

   assign hdr_bytes = eth_hdr_pack(s_hdr);
   assign cnt_inc   = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
`ifdef ETH_TX_PAD_EN
   assign cnt_plus1 = {1'b0, byte_cnt_q} + 17'd1;
`endif

   // Frame sequencing: picks the next byte for the output register and the next state.
   // A descriptor accepted while the output slot is free loads its first byte at once.
   always_comb begin
      state_d       = state_q;
      hdr_sr_d      = hdr_sr_q;
      hdr_idx_d     = hdr_idx_q;
      byte_cnt_d    = byte_cnt_q;
      load          = 1'b0;
      load_data     = '0;
      load_last     = 1'b0;
      payload_ready = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (s_hdr_valid && hdr_ready_q) begin
               state_d    = TX_HDR;
               hdr_sr_d   = hdr_bytes;
               hdr_idx_d  = 4'd0;
               byte_cnt_d = 16'd0;
               if (adv) begin
                  load       = 1'b1;
                  load_data  = hdr_bytes[HDR_BITS-1 -: 8];
                  hdr_sr_d   = hdr_bytes << 8;
                  hdr_idx_d  = 4'd1;
                  byte_cnt_d = 16'd1;
               end
            end
         end
         TX_HDR: begin
            if (adv) begin
               load       = 1'b1;
               load_data  = hdr_sr_q[HDR_BITS-1 -: 8];
               hdr_sr_d   = hdr_sr_q << 8;
               hdr_idx_d  = hdr_idx_q + 4'd1;
               byte_cnt_d = cnt_inc;
               if (hdr_idx_q == 4'(ETH_HDR_BYTES - 1)) begin
                  state_d = TX_PAYLOAD;
               end
            end
         end
         TX_PAYLOAD: begin
            payload_ready = adv;
            if (adv && s_axis_tvalid) begin
               load       = 1'b1;
               load_data  = s_axis_tdata;
               byte_cnt_d = cnt_inc;
               if (s_axis_tlast) begin
`ifdef ETH_TX_PAD_EN
                  if (cnt_plus1 < 17'(MIN_FRAME_BYTES)) begin
                     state_d = TX_PAD;
                  end else begin
                     load_last = 1'b1;
                     state_d   = TX_IDLE;
                  end
`else
                  load_last = 1'b1;
                  state_d   = TX_IDLE;
`endif
               end
            end
         end
`ifdef ETH_TX_PAD_EN
         TX_PAD: begin
            if (adv) begin
               load       = 1'b1;
               load_data  = '0;
               byte_cnt_d = cnt_inc;
               if (cnt_plus1 >= 17'(MIN_FRAME_BYTES)) begin
                  load_last = 1'b1;
                  state_d   = TX_IDLE;
               end
            end
         end
`endif
         default: begin
            state_d = TX_IDLE;
         end
      endcase
      hdr_ready_d = (state_d == TX_IDLE);
   end

   // Sequencer state; reset abandons any partial frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= TX_IDLE;
         hdr_sr_q    <= '0;
         hdr_idx_q   <= 4'd0;
         byte_cnt_q  <= 16'd0;
         hdr_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_sr_q    <= hdr_sr_d;
         hdr_idx_q   <= hdr_idx_d;
         byte_cnt_q  <= byte_cnt_d;
         hdr_ready_q <= hdr_ready_d;
      end
   end

   assign s_hdr_ready   = hdr_ready_q;
   assign s_axis_tready = payload_ready;

   eth_tx_out_reg #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_out_reg (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .load_data    (load_data),
      .load_last    (load_last),
      .m_axis_tready(m_axis_tready),
      .adv          (adv),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast (m_axis_tlast),
      .frame_done   (frame_done)
   );

endmodule

// File: tb/tb_eth_frame_builder.sv
// tb_eth_frame_builder: randomized scoreboard bench for eth_frame_builder.
// Honours ETH_TX_PAD_EN in its reference model when the build defines it.
module tb_eth_frame_builder;
   import eth_parser_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   eth_metadata_t s_hdr;
   logic          s_hdr_valid;
   logic          s_hdr_ready;
   logic [7:0]    s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [7:0]    m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic          frame_done;

   int            assertCount = 0;
   int            failCount   = 0;
   logic [8:0]    expQ[$];
   logic [8:0]    payQ[$];
   eth_metadata_t hdrQ[$];
   logic [7:0]    stimPay[$];
   int            readyMode = 0;
   int            cyc = 0;
   int            beatsSeen = 0;
   bit            hdrBusy = 1'b0;
   bit            payBusy = 1'b0;
   bit            gapCheck = 1'b0;
   bit            pendingGap = 1'b0;
   int            lastTlastCyc = 0;

   bit            prevValid, prevReady, prevLast, prevHsLast, inFrame;
   logic [7:0]    prevData;

   always #5 clk = ~clk;

   eth_frame_builder #(
      .DATA_WIDTH     (8),
      .MIN_FRAME_BYTES(ETH_MIN_FRAME_BYTES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_hdr        (s_hdr),
      .s_hdr_valid  (s_hdr_valid),
      .s_hdr_ready  (s_hdr_ready),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .frame_done   (frame_done)
   );

   // Compare one observed value against the bench's own expectation.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // An event the bench expected never happened (timeout or stray beat).
   task automatic reportFail(input string name, input string what);
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: %s (t=%0t)", name, what, $time);
   endtask

   // Reference model: the frame is header bytes MSB-first, the payload, then zeros
   // up to the minimum length when padding is built in; tlast marks the final byte.
   task automatic applyStimulus(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
      eth_metadata_t m;
      logic [7:0]    frame[$];
      m           = '0;
      m.dest_mac  = d;
      m.src_mac   = s;
      m.ethertype = t;
      m.is_ipv4   = 1'($urandom_range(0, 1));
      m.is_arp    = 1'($urandom_range(0, 1));
      m.is_ipv6   = 1'($urandom_range(0, 1));
      m.is_vlan   = 1'($urandom_range(0, 1));
      for (int i = 5; i >= 0; i--) frame.push_back(d[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) frame.push_back(s[i*8 +: 8]);
      frame.push_back(t[15:8]);
      frame.push_back(t[7:0]);
      for (int i = 0; i < stimPay.size(); i++) begin
         frame.push_back(stimPay[i]);
         payQ.push_back({(i == stimPay.size() - 1), stimPay[i]});
      end
`ifdef ETH_TX_PAD_EN
      while (frame.size() < ETH_MIN_FRAME_BYTES) frame.push_back(8'h00);
`endif
      for (int i = 0; i < frame.size(); i++) expQ.push_back({(i == frame.size() - 1), frame[i]});
      hdrQ.push_back(m);
   endtask

   // Wait until every queued frame has left the DUT, bounded in cycles.
   task automatic waitDrain(input string name);
      int budget = 0;
      while ((expQ.size() != 0 || hdrQ.size() != 0 || payQ.size() != 0 || hdrBusy || payBusy)
             && budget < 20000) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 20000) begin
         reportFail(name, "frames did not drain within 20000 cycles");
         expQ.delete();
         hdrQ.delete();
         payQ.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // Descriptor driver: presents queued descriptors and holds them until accepted.
   initial begin : hdrDriver
      int waitCyc;
      bit done;
      s_hdr       = '0;
      s_hdr_valid = 1'b0;
      forever begin
         if (hdrQ.size() == 0 || rst) begin
            @(posedge clk);
            #1;
         end else begin
            hdrBusy     = 1'b1;
            s_hdr       = hdrQ.pop_front();
            s_hdr_valid = 1'b1;
            waitCyc     = 0;
            done        = 1'b0;
            while (!done) begin
               @(negedge clk);
               waitCyc++;
               if (rst) done = 1'b1;
               else if (s_hdr_ready) done = 1'b1;
               else if (waitCyc > 3000) begin
                  reportFail("hdr_handshake", "descriptor not accepted within 3000 cycles");
                  done = 1'b1;
               end
            end
            @(posedge clk);
            #1;
            s_hdr_valid = 1'b0;
            hdrBusy     = 1'b0;
         end
      end
   end

   // Payload driver: one byte at a time with random idle gaps; drops a frame on reset.
   initial begin : payDriver
      logic [8:0] cur;
      int         waitCyc;
      bit         done, aborted;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      forever begin
         if (payQ.size() == 0 || rst) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end else begin
            payBusy = 1'b1;
            cur     = payQ.pop_front();
            if ($urandom_range(0, 3) == 0) begin
               s_axis_tvalid = 1'b0;
               @(posedge clk);
               #1;
            end
            s_axis_tdata  = cur[7:0];
            s_axis_tlast  = cur[8];
            s_axis_tvalid = 1'b1;
            waitCyc = 0;
            done    = 1'b0;
            aborted = 1'b0;
            while (!done) begin
               @(negedge clk);
               waitCyc++;
               if (rst) begin
                  aborted = 1'b1;
                  done    = 1'b1;
               end else if (s_axis_tready) done = 1'b1;
               else if (waitCyc > 3000) begin
                  reportFail("pay_handshake", "payload byte not accepted within 3000 cycles");
                  done = 1'b1;
               end
            end
            @(posedge clk);
            #1;
            s_axis_tvalid = 1'b0;
            if (aborted) begin
               while (!cur[8] && payQ.size() != 0) cur = payQ.pop_front();
            end
            payBusy = 1'b0;
         end
      end
   end

   // Downstream ready pattern: always on, 1-on/2-off, or random.
   initial begin : readyDriver
      int phase = 0;
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         phase++;
         case (readyMode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ((phase % 3) == 0);
            default: m_axis_tready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   // Monitor: pops the scoreboard on every accepted beat and checks stall hold,
   // frame_done timing, descriptor back-pressure and back-to-back spacing.
   always @(negedge clk) begin
      logic [8:0] exp;
      cyc++;
      if (rst) begin
         expQ.delete();
         prevValid  = 1'b0;
         prevReady  = 1'b0;
         prevLast   = 1'b0;
         prevData   = '0;
         prevHsLast = 1'b0;
         inFrame    = 1'b0;
         pendingGap = 1'b0;
      end else begin
         if (prevValid && !prevReady)
            checkOutput("stall_hold", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                        32'({1'b1, prevLast, prevData}));
         checkOutput("frame_done", 32'(frame_done), 32'(prevHsLast));
         if (m_axis_tvalid && !m_axis_tlast)
            checkOutput("hdr_ready_low", 32'(s_hdr_ready), 32'd0);
         if (m_axis_tvalid && !inFrame) begin
            if (pendingGap) begin
               checkOutput("b2b_gap", 32'((cyc - lastTlastCyc) <= 2), 32'd1);
               pendingGap = 1'b0;
            end
            inFrame = 1'b1;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            beatsSeen++;
            if (expQ.size() == 0) begin
               reportFail("beat_unexpected", $sformatf("data 0x%0h last %0d with empty scoreboard",
                          m_axis_tdata, m_axis_tlast));
            end else begin
               exp = expQ.pop_front();
               checkOutput("beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp));
            end
            if (m_axis_tlast) begin
               inFrame = 1'b0;
               if (gapCheck) begin
                  pendingGap   = 1'b1;
                  lastTlastCyc = cyc;
               end
            end
         end
         prevValid  = m_axis_tvalid;
         prevReady  = m_axis_tready;
         prevLast   = m_axis_tlast;
         prevData   = m_axis_tdata;
         prevHsLast = m_axis_tvalid && m_axis_tready && m_axis_tlast;
      end
   end

   // Main sequence of directed and randomized frames.
   initial begin : mainSeq
      int startBeats, budget, len;
      repeat (2) @(negedge clk);
      checkOutput("rst_hdr_ready", 32'(s_hdr_ready), 32'd0);
      checkOutput("rst_s_tready", 32'(s_axis_tready), 32'd0);
      checkOutput("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      readyMode = 0;
      stimPay   = '{8'hDE, 8'hAD, 8'hBE};
      applyStimulus(48'h112233445566, 48'hAABBCCDDEEFF, ETHERTYPE_IPV4);
      waitDrain("basic");

      readyMode = 1;
      applyStimulus(48'h112233445566, 48'hAABBCCDDEEFF, ETHERTYPE_IPV4);
      waitDrain("ready_pattern");

      readyMode = 0;
      gapCheck  = 1'b1;
      stimPay   = '{8'h01, 8'h02};
      applyStimulus(48'h0A0B0C0D0E0F, 48'h102030405060, ETHERTYPE_ARP);
      stimPay   = '{8'h03, 8'h04};
      applyStimulus(48'h6655443322FF, 48'h998877665544, ETHERTYPE_IPV6);
      waitDrain("back_to_back");
      gapCheck   = 1'b0;
      pendingGap = 1'b0;

      for (int batch = 0; batch < 6; batch++) begin
         readyMode = int'($urandom_range(0, 2));
         for (int f = 0; f < 4; f++) begin
            stimPay.delete();
            len = int'($urandom_range(1, 80));
            for (int b = 0; b < len; b++) stimPay.push_back(8'($urandom_range(0, 255)));
            applyStimulus({$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 16'($urandom));
         end
         waitDrain("random_batch");
      end

      readyMode  = 0;
      stimPay    = '{8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F, 8'h60, 8'h61, 8'h62, 8'h63};
      startBeats = beatsSeen;
      applyStimulus(48'hC0FFEE000001, 48'hBADC0DE00002, ETHERTYPE_IPV4);
      budget = 0;
      while (beatsSeen < startBeats + 5 && budget < 2000) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 2000) reportFail("reset_prep", "five beats not seen within 2000 cycles");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("midrst_m_tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("midrst_hdr_ready", 32'(s_hdr_ready), 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;

      stimPay = '{8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(48'h010203040506, 48'h0708090A0B0C, ETHERTYPE_IPV4);
      waitDrain("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
